lp_coeff_server: RTL and testbench

- Coefficient responder for the complex single-pole filter. Answers the filter's external kx_addr/ky_addr lookups with the kx/ky values.
- Host writes new coefficients into shadow registers; a commit moves them to targets.
- Active coefficients then slew toward targets in bounded steps, updated only on I/Q pair boundaries, so the filter never sees a torn or abrupt complex coefficient.
- Sits between the local-bus register decode and the filter instance.

---
 rtl/lp_coeff_server.sv | 149 ++++++++++++++
 tb/tb_lp_coeff_server.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_coeff_server.sv
// rtl/lp_coeff_server.sv - kx/ky coefficient server with pair-aligned bounded slew
// Optional feature macro: LP_COEFF_READBACK_EN (adds registered lb_rdata readback).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   iq                         pair phase, 1 = I, 0 = Q; actives move only on iq==0 edges
//   lb_write, lb_addr, lb_data host writes: 0..3 shadow kx_re/kx_im/ky_re/ky_im, 4 commit
//   kx_addr, ky_addr           lookup selects, 1 = real, 0 = imaginary
//   kx, ky                     active coefficient chosen by the lookup address (zero latency)
//   busy, done                 ramp in progress / one-cycle completion pulse
//   lb_rdata                   readback build only: active value (0..3) or busy (4), 1-cycle latency
module lp_coeff_server #(
  parameter int DW   = 18,
  parameter int STEP = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iq,
  input  logic                 lb_write,
  input  logic [2:0]           lb_addr,
  input  logic signed [DW-1:0] lb_data,
  input  logic                 kx_addr,
  input  logic                 ky_addr,
  output logic signed [DW-1:0] kx,
  output logic signed [DW-1:0] ky,
  output logic                 busy,
  output logic                 done
`ifdef LP_COEFF_READBACK_EN
  ,
  output logic signed [DW-1:0] lb_rdata
`endif
);

  typedef enum logic {S_IDLE, S_RAMP} state_e;

  localparam logic signed [DW-1:0] NEG_FS   = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] NEG_SAFE = {1'b1, {(DW-2){1'b0}}, 1'b1};
  localparam logic signed [DW:0]   STEP_W   = (DW+1)'(STEP);

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic signed [DW-1:0] shadow_q [4];
  logic signed [DW-1:0] target_q [4];
  logic signed [DW-1:0] active_q [4];
  logic signed [DW-1:0] active_d [4];
  logic signed [DW-1:0] slewed   [4];
  logic signed [DW:0]   diff     [4];
  logic signed [DW:0]   delta    [4];
  logic signed [DW:0]   sum      [4];
  logic                 commit, pair_upd, all_eq;
  logic signed [DW-1:0] wr_val;

  assign commit   = lb_write && (lb_addr == 3'd4);
  assign pair_upd = (state_q == S_RAMP) && !iq;
  // The filter cannot accept negative full scale, so nudge it one LSB inward.
  assign wr_val   = (lb_data == NEG_FS) ? NEG_SAFE : lb_data;

  // Slew: difference at DW+1 bits so large opposite-sign gaps cannot wrap;
  // the clamped sum always lies between active and target, so it fits in DW.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      diff[i] = {target_q[i][DW-1], target_q[i]} - {active_q[i][DW-1], active_q[i]};
      if (diff[i] > STEP_W) begin
        delta[i] = STEP_W;
      end else if (diff[i] < -STEP_W) begin
        delta[i] = -STEP_W;
      end else begin
        delta[i] = diff[i];
      end
      sum[i]    = {active_q[i][DW-1], active_q[i]} + delta[i];
      slewed[i] = sum[i][DW-1:0];
      if (slewed[i] != target_q[i]) begin
        all_eq = 1'b0;
      end
      active_d[i] = pair_upd ? slewed[i] : active_q[i];
    end
  end

  // A commit always (re)starts the ramp, which also suppresses done for an
  // abandoned ramp even if this edge's update happened to reach the old targets.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (commit) begin
        state_d = S_RAMP;
      end
    end else begin
      if (!commit && pair_upd && all_eq) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        target_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (lb_write && !lb_addr[2]) begin
        shadow_q[lb_addr[1:0]] <= wr_val;
      end
      for (int i = 0; i < 4; i++) begin
        if (commit) begin
          target_q[i] <= shadow_q[i];
        end
        active_q[i] <= active_d[i];
      end
    end
  end

  assign kx   = kx_addr ? active_q[0] : active_q[1];
  assign ky   = ky_addr ? active_q[2] : active_q[3];
  assign busy = (state_q == S_RAMP);
  assign done = done_q;

`ifdef LP_COEFF_READBACK_EN
  logic signed [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (!lb_addr[2]) begin
      rdata_q <= active_q[lb_addr[1:0]];
    end else if (lb_addr == 3'd4) begin
      rdata_q <= {{(DW-1){1'b0}}, busy};
    end else begin
      rdata_q <= '0;
    end
  end

  assign lb_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_lp_coeff_server.sv
// tb/tb_lp_coeff_server.sv - self-checking bench for lp_coeff_server
module tb_lp_coeff_server;
  localparam int DW   = 18;
  localparam int STEP = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 iq = 1'b1;
  logic                 lb_write = 1'b0;
  logic [2:0]           lb_addr = 3'd0;
  logic signed [DW-1:0] lb_data = '0;
  logic                 kx_addr = 1'b0;
  logic                 ky_addr = 1'b0;
  logic signed [DW-1:0] kx, ky;
  logic                 busy, done;
`ifdef LP_COEFF_READBACK_EN
  logic signed [DW-1:0] lb_rdata;
`endif

  always #5 clk = ~clk;

  lp_coeff_server #(.DW(DW), .STEP(STEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .iq       (iq),
    .lb_write (lb_write),
    .lb_addr  (lb_addr),
    .lb_data  (lb_data),
    .kx_addr  (kx_addr),
    .ky_addr  (ky_addr),
    .kx       (kx),
    .ky       (ky),
    .busy     (busy),
    .done     (done)
`ifdef LP_COEFF_READBACK_EN
    ,
    .lb_rdata (lb_rdata)
`endif
  );

  int checks = 0;
  int failures = 0;
  int dn = 0;
  int dn0;
  bit chk_en = 0;
  bit hold = 0;
  bit ph = 1;
  bit trk_sel = 0;
  int trk_last = 0;
  int chg[$];
  int exp_q[$];

  int m_sh[4], m_tg[4], m_act[4];
  int m_rd = 0;
  bit m_busy = 0, m_done = 0;

  function automatic void chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endfunction

  // Specification-level model: each iq==0 edge in a ramp moves every active
  // value toward its target by at most STEP.
  task automatic model_edge();
    int  d;
    int  nd;
    int  pre_act[4];
    bit  pre_busy;
    bit  fin;
    bit  cmt;
    pre_act  = m_act;
    pre_busy = m_busy;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 0; m_tg[i] = 0; m_act[i] = 0;
      end
      m_busy = 0; m_done = 0; m_rd = 0;
      return;
    end
    cmt = lb_write && (lb_addr == 3'd4);
    fin = 0;
    if (m_busy && !iq) begin
      fin = 1;
      for (int i = 0; i < 4; i++) begin
        d = m_tg[i] - m_act[i];
        if (d > STEP) d = STEP;
        else if (d < -STEP) d = -STEP;
        m_act[i] = m_act[i] + d;
        if (m_act[i] != m_tg[i]) fin = 0;
      end
    end
    m_done = 0;
    if (cmt) begin
      m_tg   = m_sh;
      m_busy = 1;
    end else if (fin) begin
      m_busy = 0;
      m_done = 1;
    end
    if (lb_write && lb_addr < 3'd4) begin
      nd = int'(lb_data);
      if (nd == -(1 << (DW-1))) nd = nd + 1;
      m_sh[lb_addr[1:0]] = nd;
    end
    if (lb_addr < 3'd4) m_rd = pre_act[lb_addr[1:0]];
    else if (lb_addr == 3'd4) m_rd = int'(pre_busy);
    else m_rd = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("kx", int'(kx), kx_addr ? m_act[0] : m_act[1]);
      chk("ky", int'(ky), ky_addr ? m_act[2] : m_act[3]);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
`ifdef LP_COEFF_READBACK_EN
      chk("lb_rdata", int'(lb_rdata), m_rd);
`endif
      if (done === 1'b1) dn++;
    end
  end

  task automatic drive(input bit wr, input bit [2:0] a, input int d);
    int cur;
    lb_write = wr;
    lb_addr  = a;
    lb_data  = d[DW-1:0];
    if (hold) begin
      iq = 1'b1;
    end else begin
      iq = ph;
      ph = ~ph;
    end
    @(posedge clk);
    model_edge();
    chk_en = 1;
    @(negedge clk);
    #1;
    cur = trk_sel ? int'(ky) : int'(kx);
    if (cur != trk_last) begin
      chg.push_back(cur);
      trk_last = cur;
    end
  endtask

  task automatic settrack(input bit sel);
    trk_sel = sel;
    #1;
    trk_last = sel ? int'(ky) : int'(kx);
    chg.delete();
  endtask

  // Idle cycles until done (stop_n==0) or until stop_n tracked changes.
  task automatic run_ramp(input int stop_n, input int maxc, input bit [2:0] ra);
    for (int c = 0; c < maxc; c++) begin
      drive(0, ra, 0);
      if (stop_n > 0 && chg.size() >= stop_n) return;
      if (stop_n == 0 && done) return;
    end
    checks++;
    failures++;
    $display("FAIL ramp_timeout actual=%0d changes expected=%0d", chg.size(), stop_n);
  endtask

  task automatic chk_chg(input string n);
    chk({n, "_len"}, chg.size(), exp_q.size());
    for (int i = 0; i < chg.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", n, i), chg[i], exp_q[i]);
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      kx_addr = i[0];
      ky_addr = i[1];
      drive(0, 0, 0);
    end
    chk("idle_kx", int'(kx), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done_cnt", dn, 0);

    // kx_re 0 -> 1000
    kx_addr = 1; ky_addr = 1;
    settrack(0);
    dn0 = dn;
    drive(1, 0, 1000);
    drive(1, 4, 0);
    run_ramp(0, 40, 0);
    exp_q = '{256, 512, 768, 1000};
    chk_chg("kxre_ramp");
    chk("kxre_done_cnt", dn - dn0, 1);
    drive(0, 0, 0);
    chk("kxre_busy_after", int'(busy), 0);
`ifdef LP_COEFF_READBACK_EN
    chk("rd_addr0", int'(lb_rdata), 1000);
`endif

    // ky_im written at negative full scale
    ky_addr = 0;
    settrack(1);
    dn0 = dn;
    drive(1, 3, -131072);
    drive(1, 4, 0);
    drive(0, 4, 0);
    drive(0, 4, 0);
`ifdef LP_COEFF_READBACK_EN
    chk("rd_addr4_busy", int'(lb_rdata), 1);
`endif
    run_ramp(0, 1200, 3);
    chk("kyim_len", chg.size(), 512);
    chk("kyim_first", (chg.size() > 0) ? chg[0] : 0, -256);
    chk("kyim_last", (chg.size() > 0) ? chg[chg.size()-1] : 0, -131071);
    chk("kyim_done_cnt", dn - dn0, 1);
    drive(0, 4, 0);
`ifdef LP_COEFF_READBACK_EN
    chk("rd_addr4_idle", int'(lb_rdata), 0);
`endif

    // ky_re retargeted mid-ramp; shadow rewritten while ramping
    ky_addr = 1;
    settrack(1);
    dn0 = dn;
    drive(1, 2, 20000);
    drive(1, 4, 0);
    drive(1, 2, 0);
    run_ramp(3, 40, 2);
    drive(1, 4, 0);
    run_ramp(0, 40, 2);
    exp_q = '{256, 512, 768, 512, 256, 0};
    chk_chg("kyre_retarget");
    chk("kyre_done_cnt", dn - dn0, 1);

    // kx_im: stall with iq held, then commit on an update edge, then reset
    kx_addr = 0;
    settrack(0);
    dn0 = dn;
    drive(1, 1, 5000);
    drive(1, 4, 0);
    hold = 1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) drive(1, 1, -100);
      else drive(0, 1, 0);
    end
    chk("stall_busy", int'(busy), 1);
    chk("stall_kx", int'(kx), 0);
    hold = 0;
    ph = 0;
    for (int i = 0; i < 4; i++) drive(0, 1, 0);
    drive(1, 4, 0);
    run_ramp(0, 40, 1);
    exp_q = '{256, 512, 768, 512, 256, 0, -100};
    chk_chg("kxim_ramp");
    chk("kxim_done_cnt", dn - dn0, 1);
    drive(1, 1, 3000);
    drive(1, 4, 0);
    run_ramp(9, 40, 1);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1;
    drive(0, 0, 0);
    rst = 0;
    chk("rst_kx_im", int'(kx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    kx_addr = 1;
    #1;
    chk("rst_kx_re", int'(kx), 0);
    chk("rst_ky_re", int'(ky), 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0);
    chk("rst_done_cnt", dn - dn0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
